// File: rtl/hsd_accumulator.sv
// hsd_accumulator: carry-free redundant accumulator with a chunked
// borrow-chain conversion back to binary on flush.
// The accumulator is kept as two vectors P and N with value (P - N) mod 2^WIDTH,
// so each operand is absorbed in one cycle without a carry chain. On flush, a
// CHUNK-bit subtractor walks from the LSB chunk upward for WIDTH/CHUNK cycles,
// then the result is held until it is consumed.
// Optional feature: define HSD_ACC_CNT_EN to add the acc_count output
// (operands accepted since reset or clr, saturating at 16'hFFFF).
module hsd_accumulator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  input  logic             flush_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef HSD_ACC_CNT_EN
  ,
  output logic [15:0]      acc_count
`endif
);

  localparam int K     = WIDTH / CHUNK;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_ACC, S_CONV, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_out;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_acc;
  logic             w_accept;
  logic             w_clr;
  logic             w_last;
  logic [WIDTH-1:0] w_p_base;
  logic [WIDTH-1:0] w_n_base;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_u;
  logic [CHUNK-1:0] w_p_chunk;
  logic [CHUNK-1:0] w_n_chunk;
  logic [CHUNK-1:0] w_diff;
  logic             w_borrow_out;

  // Saturating 16-bit increment used by the optional operand counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_in_acc = (r_state == S_ACC);
  assign w_accept = w_in_acc & in_valid;
  assign w_clr    = w_in_acc & clr;
  assign w_last   = (r_cnt == CNT_W'(K - 1));

  // Carry-free add of the operand; clear is folded in ahead of the add.
  always_comb begin
    w_p_base = w_clr ? '0 : r_p;
    w_n_base = w_clr ? '0 : r_n;
    w_t      = (w_p_base & ~w_n_base) | (w_p_base & in_data) | (~w_n_base & in_data);
    w_u      = w_p_base ^ w_n_base ^ in_data;
  end

  // Select the current P/N chunk and subtract it with the running borrow.
  always_comb begin
    w_p_chunk = '0;
    w_n_chunk = '0;
    for (int k = 0; k < K; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_p_chunk = r_p[k*CHUNK +: CHUNK];
        w_n_chunk = r_n[k*CHUNK +: CHUNK];
      end
    end
    {w_borrow_out, w_diff} = {1'b0, w_p_chunk} - {1'b0, w_n_chunk} - {{CHUNK{1'b0}}, r_borrow};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_next;
  end

  // Next-state logic: flush starts conversion, K chunks later hold until consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACC:   if (flush_req) w_next = S_CONV;
      S_CONV:  if (w_last)    w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_ACC;
      default: w_next = S_ACC;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (r_state == S_ACC);
    out_valid = (r_state == S_HOLD);
    busy      = (r_state == S_CONV) | (r_state == S_HOLD);
  end

  assign out_data = r_out;

  // Accumulator, conversion chunk counter, borrow and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p      <= '0;
      r_n      <= '0;
      r_out    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_p <= {w_t[WIDTH-2:0], 1'b0};
            r_n <= w_u;
          end else if (w_clr) begin
            r_p <= '0;
            r_n <= '0;
          end
          if (flush_req) begin
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_CONV: begin
          for (int k = 0; k < K; k++) begin
            if (r_cnt == CNT_W'(k)) r_out[k*CHUNK +: CHUNK] <= w_diff;
          end
          r_borrow <= w_borrow_out;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HSD_ACC_CNT_EN
  logic [15:0] r_count;

  // Operand counter; only moves in ACC, so it is frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 16'd0;
    end else if (w_in_acc) begin
      if (w_clr)         r_count <= w_accept ? 16'd1 : 16'd0;
      else if (w_accept) r_count <= sat_inc16(r_count);
    end
  end

  assign acc_count = r_count;
`endif

endmodule
